// File: rtl/dense_layer_scheduler_pkg.sv
// Shared definitions for the dense-layer scheduler: FSM states and the per-layer
// configuration table (sizes, weight/bias ROM base addresses).
package dense_layer_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_NEXT,
        S_ARGMAX,
        S_DONE
    } sched_state_e;

    // MNIST network 784->32->10, with room for up to four passes.
    function automatic int layer_in(input int l);
        case (l)
            0:       return 784;
            1:       return 32;
            default: return 10;
        endcase
    endfunction

    function automatic int layer_out(input int l);
        case (l)
            0:       return 32;
            default: return 10;
        endcase
    endfunction

    // Weight bases are the running sum of in*out of all earlier layers.
    function automatic int layer_w_base(input int l);
        case (l)
            0:       return 0;
            1:       return 25088;
            2:       return 25408;
            default: return 25508;
        endcase
    endfunction

    function automatic int layer_b_base(input int l);
        case (l)
            0:       return 0;
            1:       return 32;
            2:       return 42;
            default: return 52;
        endcase
    endfunction

endpackage

// File: rtl/dense_argmax.sv
// Streams NUM_CLASSES scores out of the outputs RAM and tracks the signed maximum;
// ties keep the lowest index.
module dense_argmax #(
    parameter int DATA_SIZE   = 16,
    parameter int MAX_OUT     = 64,
    parameter int NUM_CLASSES = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             go,
    input  logic                             buf_sel,
    input  logic [DATA_SIZE-1:0]             ram_dataOut,
    output logic                             done,
    output logic                             ram_rd,
    output logic [$clog2(MAX_OUT):0]         ram_adr,
    output logic [$clog2(NUM_CLASSES)-1:0]   class_out
);
    localparam int IDX_W = $clog2(MAX_OUT);
    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_cmp_idx;
    logic                 r_issued;
    logic                 r_cmp_vld;
    logic [DATA_SIZE-1:0] r_max;
    logic [CLS_W-1:0]     r_max_idx;
    logic                 w_take;

    assign ram_rd  = go && !r_issued;
    assign ram_adr = ram_rd ? {buf_sel, r_idx} : '0;

    // Index 0 seeds the running max; later words replace it only when strictly greater.
    assign w_take    = r_cmp_vld && ((r_cmp_idx == '0) || ($signed(ram_dataOut) > $signed(r_max)));
    assign done      = r_cmp_vld && (r_cmp_idx == LAST);
    assign class_out = w_take ? CLS_W'(r_cmp_idx) : r_max_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_cmp_idx <= '0;
            r_issued  <= 1'b0;
            r_cmp_vld <= 1'b0;
            r_max     <= '0;
            r_max_idx <= '0;
        end else begin
            r_cmp_vld <= ram_rd;
            r_cmp_idx <= r_idx;
            if (!go) begin
                r_idx    <= '0;
                r_issued <= 1'b0;
            end else if (ram_rd) begin
                r_issued <= (r_idx == LAST);
                r_idx    <= r_idx + 1'b1;
            end
            if (w_take) begin
                r_max     <= ram_dataOut;
                r_max_idx <= CLS_W'(r_cmp_idx);
            end
        end
    end

endmodule

// File: rtl/dense_layer_scheduler.sv
// Sequences the shared Dense engine through LAYERS passes with ping-pong output
// buffers, then runs an argmax over the final scores to produce the class.
module dense_layer_scheduler
    import dense_layer_scheduler_pkg::*;
#(
    parameter int LAYERS      = 2,
    parameter int DATA_SIZE   = 16,
    parameter int MAX_OUT     = 64,
    parameter int NUM_CLASSES = 10,
    parameter int W_ADR_W     = 16,
    parameter int B_ADR_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_CLASSES)-1:0] class_out,
    output logic                           eng_start,
    input  logic                           eng_busy,
    input  logic                           eng_valid,
    output logic [15:0]                    cfg_in_count,
    output logic [15:0]                    cfg_out_count,
    output logic [W_ADR_W-1:0]             cfg_w_base,
    output logic [B_ADR_W-1:0]             cfg_b_base,
    output logic                           cfg_buf_sel,
    output logic [$clog2(LAYERS):0]        layer_idx,
    output logic                           ram_rd,
    output logic [$clog2(MAX_OUT):0]       ram_adr,
    input  logic [DATA_SIZE-1:0]           ram_dataOut
);
    localparam int LI_W  = $clog2(LAYERS) + 1;
    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam logic [LI_W-1:0] LAST_LAYER = LI_W'(LAYERS - 1);

    sched_state_e     r_state, w_next;
    logic [LI_W-1:0]  r_layer_idx;
    logic             r_buf_sel;
    logic [CLS_W-1:0] r_class_out;
    logic [CLS_W-1:0] w_am_class;
    logic             w_am_go;
    logic             w_am_done;
    logic             w_last;

    assign w_last = (r_layer_idx == LAST_LAYER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        eng_start = 1'b0;
        done      = 1'b0;
        w_am_go   = 1'b0;
        case (r_state)
            S_IDLE:      if (start) w_next = S_LAUNCH;
            S_LAUNCH: begin
                eng_start = 1'b1;
                w_next    = S_WAIT_BUSY;
            end
            // A fast engine may report valid without ever raising busy.
            S_WAIT_BUSY: begin
                if (eng_valid)     w_next = S_NEXT;
                else if (eng_busy) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (eng_valid) w_next = S_NEXT;
            S_NEXT:      w_next = w_last ? S_ARGMAX : S_LAUNCH;
            S_ARGMAX: begin
                w_am_go = 1'b1;
                if (w_am_done) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_layer_idx <= '0;
            r_buf_sel   <= 1'b0;
            r_class_out <= '0;
        end else begin
            if (r_state == S_NEXT && !w_last) begin
                r_layer_idx <= r_layer_idx + 1'b1;
                r_buf_sel   <= ~r_buf_sel;
            end else if (r_state == S_DONE) begin
                r_layer_idx <= '0;
                r_buf_sel   <= 1'b0;
            end
            if (r_state == S_ARGMAX && w_am_done) r_class_out <= w_am_class;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign layer_idx   = r_layer_idx;
    assign cfg_buf_sel = r_buf_sel;
    assign class_out   = r_class_out;

    // Table values are blanked while idle so the engine sees an all-zero config at rest.
    assign cfg_in_count  = busy ? 16'(layer_in(int'(r_layer_idx)))          : '0;
    assign cfg_out_count = busy ? 16'(layer_out(int'(r_layer_idx)))         : '0;
    assign cfg_w_base    = busy ? W_ADR_W'(layer_w_base(int'(r_layer_idx))) : '0;
    assign cfg_b_base    = busy ? B_ADR_W'(layer_b_base(int'(r_layer_idx))) : '0;

    dense_argmax #(
        .DATA_SIZE  (DATA_SIZE),
        .MAX_OUT    (MAX_OUT),
        .NUM_CLASSES(NUM_CLASSES)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .go         (w_am_go),
        .buf_sel    (r_buf_sel),
        .ram_dataOut(ram_dataOut),
        .done       (w_am_done),
        .ram_rd     (ram_rd),
        .ram_adr    (ram_adr),
        .class_out  (w_am_class)
    );

endmodule

// File: tb/tb_dense_layer_scheduler.sv
// Directed bench for dense_layer_scheduler: table of score vectors with expected
// class, plus hand sequences for reset, start-hold, start-ignore and stale valid.
module tb_dense_layer_scheduler;
    localparam int NC      = 10;
    localparam int ENG_DLY = 20;

    typedef struct packed {
        logic [NC-1:0][15:0] sc;
        logic [3:0]          cls;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        eng_busy = 1'b0, eng_valid = 1'b0;
    logic        busy, done, eng_start, cfg_buf_sel, ram_rd;
    logic [3:0]  class_out;
    logic [15:0] cfg_in_count, cfg_out_count, cfg_w_base;
    logic [7:0]  cfg_b_base;
    logic [1:0]  layer_idx;
    logic [6:0]  ram_adr;
    logic [15:0] ram_dataOut = '0;
    logic [15:0] mem [128];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, k = 0, n_start = 0, n_done = 0, cnt = 0, overlap = 0;
    int last_valid_cyc = 0, done_cyc = 0;
    bit fast_eng = 1'b0, stale_req = 1'b0;
    int exp_in [2] = '{784, 32};
    int exp_out[2] = '{32, 10};
    int exp_w  [2] = '{0, 25088};
    int exp_b  [2] = '{0, 32};

    vec_t vecs[6];
    int   nv = 0;

    dense_layer_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .class_out(class_out), .eng_start(eng_start), .eng_busy(eng_busy),
        .eng_valid(eng_valid), .cfg_in_count(cfg_in_count), .cfg_out_count(cfg_out_count),
        .cfg_w_base(cfg_w_base), .cfg_b_base(cfg_b_base), .cfg_buf_sel(cfg_buf_sel),
        .layer_idx(layer_idx), .ram_rd(ram_rd), .ram_adr(ram_adr), .ram_dataOut(ram_dataOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rd) ram_dataOut <= mem[ram_adr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor + engine model: sample DUT outputs, then update engine inputs.
    always @(negedge clk) begin
        int kk;
        cyc++;
        if (eng_start && ram_rd) overlap++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (eng_start) begin
            n_start++;
            kk = (k > 1) ? 1 : k;
            check("cfg_layer_idx", 32'(layer_idx), 32'(k));
            check("cfg_in_count", 32'(cfg_in_count), 32'(exp_in[kk]));
            check("cfg_out_count", 32'(cfg_out_count), 32'(exp_out[kk]));
            check("cfg_w_base", 32'(cfg_w_base), 32'(exp_w[kk]));
            check("cfg_b_base", 32'(cfg_b_base), 32'(exp_b[kk]));
            check("cfg_buf_sel", 32'(cfg_buf_sel), 32'(k % 2));
            k++;
        end
        if (done || rst) k = 0;
        if (rst) begin
            cnt = 0; eng_busy = 1'b0; eng_valid = 1'b0;
        end else begin
            eng_valid = 1'b0;
            if (eng_start) begin
                cnt      = fast_eng ? 2 : ENG_DLY;
                eng_busy = !fast_eng;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_busy = 1'b0;
                    eng_valid = 1'b1;
                    last_valid_cyc = cyc;
                end
            end
            if (stale_req) eng_valid = 1'b1;
        end
    end

    task automatic add_vec(input int s[NC], input int c);
        for (int i = 0; i < NC; i++) vecs[nv].sc[i] = 16'(s[i]);
        vecs[nv].cls = 4'(c);
        nv++;
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < NC; i++) mem[64+i] = vecs[v].sc[i];
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_eng_start"}, 32'(eng_start), 0);
        check({tag, "_class_out"}, 32'(class_out), 0);
        check({tag, "_cfg_in"}, 32'(cfg_in_count), 0);
        check({tag, "_cfg_out"}, 32'(cfg_out_count), 0);
        check({tag, "_cfg_w"}, 32'(cfg_w_base), 0);
        check({tag, "_cfg_b"}, 32'(cfg_b_base), 0);
        check({tag, "_buf_sel"}, 32'(cfg_buf_sel), 0);
        check({tag, "_layer_idx"}, 32'(layer_idx), 0);
        check({tag, "_ram_rd"}, 32'(ram_rd), 0);
        check({tag, "_ram_adr"}, 32'(ram_adr), 0);
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            got = done;
        end
        if (!got) check(tag, 0, 1);
    endtask

    // Full run on vector v; optionally pulse start pulse_at cycles after launch.
    task automatic run_vec(input int v, input int pulse_at);
        int s0, d0;
        bit got = 1'b0;
        load_vec(v);
        s0 = n_start;
        d0 = n_done;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start_to_eng_start", 32'(eng_start), 1);
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            got = done;
            if (c == pulse_at) start = 1'b1;
            else if (c == pulse_at + 1) start = 1'b0;
        end
        if (!got) check("done_timeout", 0, 1);
        @(posedge clk); #1;
        check("class_out", 32'(class_out), 32'(vecs[v].cls));
        check("done_count", 32'(n_done - d0), 1);
        check("eng_start_count", 32'(n_start - s0), 2);
        check("valid_to_done", 32'(done_cyc - last_valid_cyc), NC + 3);
        check("done_one_cycle", 32'(done), 0);
    endtask

    initial begin
        int s [NC];
        int s0;
        bit got;
        s = '{3, -5, 7, 7, 2, 0, 1, 6, -9, 4};                  add_vec(s, 2);
        s = '{-10, -20, -3, -4, -50, -6, -7, -8, -2, -1};       add_vec(s, 9);
        s = '{100, 5, 5, 5, 5, 5, 5, 5, 5, 5};                  add_vec(s, 0);
        s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};                    add_vec(s, 0);
        s = '{-32768, 0, 0, 0, 0, 32767, 0, 0, 0, 32767};       add_vec(s, 5);
        s = '{5, -1, -2, -3, -4, -5, -6, -7, -8, 6};            add_vec(s, 9);
        for (int i = 0; i < 128; i++) mem[i] = (i < 64) ? 16'h7FFF : 16'h0000;

        rst = 1'b1; start = 1'b0;
        #7;
        check_reset("por");
        @(posedge clk); #1 rst = 1'b0;

        // Table-driven runs: vector 2 gets a start pulse during WAIT_DONE,
        // vector 3 uses an engine that never raises busy.
        for (int v = 0; v < nv; v++) begin
            fast_eng = (v == 3);
            run_vec(v, (v == 2) ? 8 : -1);
        end
        fast_eng = 1'b0;

        // start held high: relaunch the cycle after IDLE is re-entered.
        @(posedge clk); #1 start = 1'b1;
        wait_done("hold_done1_timeout");
        check("hold_class1", 32'(class_out), 32'(vecs[5].cls));
        @(negedge clk);
        check("hold_idle_busy", 32'(busy), 0);
        @(negedge clk);
        check("hold_relaunch", 32'(eng_start), 1);
        start = 1'b0;
        wait_done("hold_done2_timeout");
        @(posedge clk); #1;
        check("hold_class2", 32'(class_out), 32'(vecs[5].cls));

        // Async reset in the middle of argmax.
        load_vec(0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            got = ram_rd;
        end
        if (!got) check("argmax_timeout", 0, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1 check_reset("async");
        @(posedge clk); #1 rst = 1'b0;
        s0 = n_start;
        repeat (30) @(posedge clk);
        #1 check("no_start_after_rst", 32'(n_start - s0), 0);

        // Reset during WAIT_DONE of layer 1, stale valid in IDLE, then restart.
        load_vec(1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            got = eng_start && (layer_idx == 2'd1);
        end
        if (!got) check("layer1_timeout", 0, 1);
        repeat (5) @(negedge clk);
        check("l1_wait_busy", 32'(busy), 1);
        check("l1_layer_idx", 32'(layer_idx), 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("l1rst_layer_idx", 32'(layer_idx), 0);
        check("l1rst_buf_sel", 32'(cfg_buf_sel), 0);
        check("l1rst_busy", 32'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        s0 = n_start;
        stale_req = 1'b1;
        @(posedge clk); #1 stale_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stale_valid_busy", 32'(busy), 0);
        check("stale_valid_start", 32'(n_start - s0), 0);
        run_vec(1, -1);

        check("rd_start_overlap", 32'(overlap), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
